// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline sequencer.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MISS_REQ = 2'd1,
    REFILL   = 2'd2
  } ctrl_state_t;

  localparam logic [4:0]  REG_ZERO      = 5'd0;
  localparam int unsigned CNT_W_DEFAULT = 32;

endpackage

// File: rtl/sat_counter.sv
// Event counter that saturates at all-ones; synchronous active-high clear.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: load-use/branch control, D-cache miss handshake and
// saturating stall/bubble/flush performance counters.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rt_i,
  input  logic             branch_taken_i,
  input  logic             dcache_miss_i,
  input  logic             mem_ack_i,
  output logic             stall_o,
  output logic             pc_write_o,
  output logic             ifid_hazard_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             mem_req_o,
  output logic             refill_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  ctrl_state_t state_q, state_d;
  logic        load_use;

  assign load_use = ex_memread_i && (ex_rt_i != REG_ZERO) &&
                    ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

  always_comb begin
    state_d       = state_q;
    stall_o       = 1'b0;
    pc_write_o    = 1'b1;
    ifid_hazard_o = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    mem_req_o     = 1'b0;
    refill_o      = 1'b0;
    unique case (state_q)
      RUN: begin
        // Miss outranks load-use, which in turn suppresses a coincident branch.
        if (dcache_miss_i) begin
          stall_o    = 1'b1;
          pc_write_o = 1'b0;
          state_d    = MISS_REQ;
        end else if (load_use) begin
          ifid_hazard_o = 1'b1;
          idex_bubble_o = 1'b1;
          pc_write_o    = 1'b0;
        end else if (branch_taken_i) begin
          ifid_flush_o = 1'b1;
        end
      end
      MISS_REQ: begin
        stall_o    = 1'b1;
        pc_write_o = 1'b0;
        mem_req_o  = 1'b1;
        if (mem_ack_i) state_d = REFILL;
      end
      REFILL: begin
        stall_o    = 1'b1;
        pc_write_o = 1'b0;
        refill_o   = 1'b1;
        state_d    = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= RUN;
    else       state_q <= state_d;
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall_o),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (idex_bubble_o),
    .cnt_o (bubble_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (ifid_flush_o),
    .cnt_o (flush_cnt_o)
  );

endmodule
